game_countdown_timer: RTL and testbench

Consumer of the free-running 10 Hz system time count (20-bit tenths-of-second value) produced by the system clock block. Converts count increments into a loadable, pausable gameplay countdown in tenths of a second. Outputs binary remaining time, three BCD digits for the score/HUD display, and a one-cycle expiry pulse to the game-state controller.

---
 rtl/game_countdown_timer.sv | 168 ++++++++++++++++
 tb/tb_game_countdown_timer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// Pausable tenths-of-second gameplay countdown driven by the 10 Hz system time count.
// Optional macro WARN_BLINK_EN makes warn toggle on each tick instead of holding high.
module game_countdown_timer #(
  parameter int TIME_W      = 20,
  parameter int MAX_LOAD    = 999,
  parameter int WARN_THRESH = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] tick_time,
  input  logic [9:0]        load_value,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [9:0]        time_left,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones,
  output logic [3:0]        bcd_tenths,
  output logic              running,
  output logic              expired,
  output logic              warn
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUNNING = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [9:0] MAX_L  = 10'(MAX_LOAD);
  localparam logic [9:0] WARN_L = 10'(WARN_THRESH);

  logic [1:0]        state_q, state_d;
  logic [TIME_W-1:0] prev_time_q;
  logic [9:0]        time_left_q, time_left_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic [3:0]        tenths_q, tenths_d;
  logic              running_q, running_d;
  logic              expired_q, expired_d;
  logic              warn_q, warn_d;
  logic              tick;
  logic              warn_cond;
  logic [9:0]        load_sat;
  logic [11:0]       load_bcd;

  // Shift-add-3 conversion, only used when loading.
  function automatic logic [11:0] to_bcd(input logic [9:0] bin);
    logic [21:0] s;
    s = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (s[13:10] >= 4'd5) s[13:10] = s[13:10] + 4'd3;
      if (s[17:14] >= 4'd5) s[17:14] = s[17:14] + 4'd3;
      if (s[21:18] >= 4'd5) s[21:18] = s[21:18] + 4'd3;
      s = s << 1;
    end
    return s[21:10];
  endfunction

  assign tick     = (tick_time == prev_time_q + TIME_W'(1));
  assign load_sat = (load_value > MAX_L) ? MAX_L : load_value;
  assign load_bcd = to_bcd(load_sat);

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    tenths_d    = tenths_q;
    expired_d   = 1'b0;
    if (stop) begin
      state_d     = S_IDLE;
      time_left_d = 10'd0;
      tens_d      = 4'd0;
      ones_d      = 4'd0;
      tenths_d    = 4'd0;
    end else if (start) begin
      time_left_d = load_sat;
      tens_d      = load_bcd[11:8];
      ones_d      = load_bcd[7:4];
      tenths_d    = load_bcd[3:0];
      if (load_sat == 10'd0) begin
        state_d   = S_EXPIRED;
        expired_d = 1'b1;
      end else begin
        state_d   = S_RUNNING;
      end
    end else if (pause) begin
      if (state_q == S_RUNNING) state_d = S_PAUSED;
      else if (state_q == S_PAUSED) state_d = S_RUNNING;
    end else if (tick && state_q == S_RUNNING) begin
      time_left_d = time_left_q - 10'd1;
      // Borrow cascade: tenths -> ones -> tens.
      if (tenths_q != 4'd0) begin
        tenths_d = tenths_q - 4'd1;
      end else begin
        tenths_d = 4'd9;
        if (ones_q != 4'd0) begin
          ones_d = ones_q - 4'd1;
        end else begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end
      end
      if (time_left_q == 10'd1) begin
        state_d   = S_EXPIRED;
        expired_d = 1'b1;
      end
    end
  end

  assign running_d = (state_d == S_RUNNING);
  assign warn_cond = (state_d == S_RUNNING || state_d == S_PAUSED) &&
                     (time_left_d <= WARN_L) && (time_left_d != 10'd0);

`ifdef WARN_BLINK_EN
  logic warn_cond_q;

  always_comb begin
    warn_d = warn_q;
    if (!warn_cond)
      warn_d = 1'b0;
    else if (!warn_cond_q)
      warn_d = 1'b1;
    else if (tick && state_q == S_RUNNING && !stop && !start && !pause)
      warn_d = ~warn_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) warn_cond_q <= 1'b0;
    else        warn_cond_q <= warn_cond;
  end
`else
  assign warn_d = warn_cond;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      prev_time_q <= '0;
      time_left_q <= 10'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      tenths_q    <= 4'd0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      warn_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_time_q <= tick_time;
      time_left_q <= time_left_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      tenths_q    <= tenths_d;
      running_q   <= running_d;
      expired_q   <= expired_d;
      warn_q      <= warn_d;
    end
  end

  assign time_left  = time_left_q;
  assign bcd_tens   = tens_q;
  assign bcd_ones   = ones_q;
  assign bcd_tenths = tenths_q;
  assign running    = running_q;
  assign expired    = expired_q;
  assign warn       = warn_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed vector bench for game_countdown_timer (default build, steady warn).
module tb_game_countdown_timer;

  logic        clk;
  logic        reset;
  logic [19:0] tick_time;
  logic [9:0]  load_value;
  logic        start, pause, stop;
  logic [9:0]  time_left;
  logic [3:0]  bcd_tens, bcd_ones, bcd_tenths;
  logic        running, expired, warn;

  int total;
  int passed;

  game_countdown_timer dut (
    .clk        (clk),
    .reset      (reset),
    .tick_time  (tick_time),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .time_left  (time_left),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .bcd_tenths (bcd_tenths),
    .running    (running),
    .expired    (expired),
    .warn       (warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         st, pa, sp, tk;
    logic [9:0] ld;
    int         tl, tens, ones, tenths;
    bit         run, ex, wr;
  } vec_t;

  function automatic vec_t mk(bit st, bit pa, bit sp, bit tk, int ld,
                              int tl, bit run, bit ex, bit wr);
    vec_t v;
    v.st = st; v.pa = pa; v.sp = sp; v.tk = tk;
    v.ld = 10'(ld);
    v.tl = tl;
    v.tens = tl / 100;
    v.ones = (tl / 10) % 10;
    v.tenths = tl % 10;
    v.run = run; v.ex = ex; v.wr = wr;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(string nm, int tl, bit run, bit ex, bit wr);
    chk({nm, " time_left"}, int'(time_left), tl);
    chk({nm, " tens"}, int'(bcd_tens), tl / 100);
    chk({nm, " ones"}, int'(bcd_ones), (tl / 10) % 10);
    chk({nm, " tenths"}, int'(bcd_tenths), tl % 10);
    chk({nm, " running"}, int'(running), int'(run));
    chk({nm, " expired"}, int'(expired), int'(ex));
    chk({nm, " warn"}, int'(warn), int'(wr));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; pause = 0; stop = 0;
  endtask

  task automatic tick_once();
    tick_time = tick_time + 20'd1;
    cyc();
  endtask

  vec_t v[22];

  initial begin
    total = 0;
    passed = 0;
    reset = 0;
    tick_time = 0;
    load_value = 0;
    idle_in();

    v[0]  = mk(1,0,0,0,1000, 999, 1,0,0);
    v[1]  = mk(0,0,0,1,0,    998, 1,0,0);
    v[2]  = mk(1,0,0,0,100,  100, 1,0,0);
    v[3]  = mk(0,0,0,1,0,     99, 1,0,0);
    v[4]  = mk(1,0,0,0,51,    51, 1,0,0);
    v[5]  = mk(0,0,0,1,0,     50, 1,0,1);
    v[6]  = mk(0,1,0,0,0,     50, 0,0,1);
    v[7]  = mk(0,0,0,1,0,     50, 0,0,1);
    v[8]  = mk(0,1,0,0,0,     50, 1,0,1);
    v[9]  = mk(1,0,0,0,2,      2, 1,0,1);
    v[10] = mk(0,0,0,1,0,      1, 1,0,1);
    v[11] = mk(0,0,0,1,0,      0, 0,1,0);
    v[12] = mk(0,0,0,0,0,      0, 0,0,0);
    v[13] = mk(0,0,0,1,0,      0, 0,0,0);
    v[14] = mk(0,1,0,0,0,      0, 0,0,0);
    v[15] = mk(1,0,0,1,7,      7, 1,0,1);
    v[16] = mk(0,0,0,1,0,      6, 1,0,1);
    v[17] = mk(1,0,1,0,9,      0, 0,0,0);
    v[18] = mk(1,0,0,0,0,      0, 0,1,0);
    v[19] = mk(0,0,0,0,0,      0, 0,0,0);
    v[20] = mk(0,0,1,0,0,      0, 0,0,0);
    v[21] = mk(0,1,0,0,0,      0, 0,0,0);

    #12;
    chk_all("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1;
    cyc();
    chk_all("post_reset", 0, 0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      start = v[i].st; pause = v[i].pa; stop = v[i].sp;
      load_value = v[i].ld;
      if (v[i].tk) tick_time = tick_time + 20'd1;
      cyc();
      chk_all($sformatf("vec%0d", i), v[i].tl, v[i].run, v[i].ex, v[i].wr);
    end
    idle_in();

    // Full 25-tick countdown with expiry pulse
    load_value = 25; start = 1;
    cyc();
    idle_in();
    chk_all("cd25 load", 25, 1, 0, 1);
    for (int i = 1; i <= 25; i++) begin
      tick_once();
      chk($sformatf("cd25 tl%0d", i), int'(time_left), 25 - i);
      chk($sformatf("cd25 ex%0d", i), int'(expired), (i == 25) ? 1 : 0);
    end
    cyc();
    chk_all("cd25 after", 0, 0, 0, 0);
    tick_once();
    chk("cd25 hold", int'(time_left), 0);

    // Pause window swallows ticks
    load_value = 40; start = 1;
    cyc();
    idle_in();
    pause = 1;
    cyc();
    pause = 0;
    for (int i = 0; i < 10; i++) tick_once();
    chk_all("paused", 40, 0, 0, 1);
    pause = 1;
    cyc();
    pause = 0;
    for (int i = 0; i < 3; i++) tick_once();
    chk_all("resumed", 37, 1, 0, 1);

    // Producer jumps are not ticks
    load_value = 10; start = 1;
    cyc();
    idle_in();
    tick_time = 20'd1000000;
    cyc();
    chk("jump 1000000", int'(time_left), 10);
    tick_time = 20'd1000001;
    cyc();
    chk("step 1000001", int'(time_left), 9);
    tick_time = 20'd0;
    cyc();
    chk("wrap 0", int'(time_left), 9);
    tick_time = 20'd1;
    cyc();
    chk_all("step 1", 8, 1, 0, 1);
    cyc();
    chk("equal no tick", int'(time_left), 8);

    // Asynchronous reset mid-count
    load_value = 30; start = 1;
    cyc();
    idle_in();
    chk("pre_reset", int'(time_left), 30);
    #2;
    reset = 0;
    #1;
    chk_all("async reset", 0, 0, 0, 0);
    cyc();
    chk_all("reset held", 0, 0, 0, 0);
    reset = 1;
    cyc();
    chk_all("reset release", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
